// File: rtl/dmem_responder.sv
// Single-port data memory responder on a req/gnt/rvalid bus with a programmable grant latency.
// Out-of-range accesses complete normally but return rdata=0 with data_err_o set.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) * 32'd4;
  localparam logic [3:0]  WAIT_C    = 4'(WAIT_CYCLES);
  localparam logic        ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [31:0]     offset_s;
  logic            in_range_s;
  logic [AW-1:0]   idx_s;
  logic            gnt_s;
  logic            wr_en_s;

  // Both bounds are checked separately so an address below BASE_ADDR cannot wrap into range.
  assign offset_s   = data_addr_i - BASE_ADDR;
  assign in_range_s = (data_addr_i >= BASE_ADDR) && (offset_s < SPAN);
  assign idx_s      = offset_s[AW+1:2];

  // Grant decode; suppressed while reset is held so nothing is accepted mid-reset.
  always_comb begin
    gnt_s = 1'b0;
    if (rst_i) begin
      gnt_s = 1'b0;
    end else if (!data_req_i) begin
      gnt_s = 1'b0;
    end else if (state_q == ST_WAIT) begin
      gnt_s = (wait_cnt_q == WAIT_C);
    end else begin
      gnt_s = ZERO_WAIT;
    end
  end

  assign wr_en_s = gnt_s & data_we_i & in_range_s;

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (!data_req_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else if (ZERO_WAIT) begin
          state_d    = ST_RESP;
          wait_cnt_d = 4'd0;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = 4'd1;
        end
      end
      ST_WAIT: begin
        if (!data_req_i) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q == WAIT_C) begin
          state_d    = ST_RESP;
          wait_cnt_d = 4'd0;
        end else begin
          state_d    = ST_WAIT;
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Response data captured at the grant edge; held otherwise.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (!gnt_s) begin
      rdata_d = rdata_q;
      err_d   = err_q;
    end else if (!in_range_s) begin
      rdata_d = 32'h0000_0000;
      err_d   = 1'b1;
    end else if (data_we_i) begin
      rdata_d = 32'h0000_0000;
      err_d   = 1'b0;
    end else begin
      rdata_d = mem_q[idx_s];
      err_d   = 1'b0;
    end
  end

  // Control and response registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      rdata_q    <= 32'h0000_0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // Storage has no reset; only enabled byte lanes are written.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int k = 0; k < 4; k++) begin
        if (data_be_i[k]) begin
          mem_q[idx_s][8*k +: 8] <= data_wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign data_gnt_o    = gnt_s;
  assign data_rvalid_o = (state_q == ST_RESP);
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: one zero-latency instance (1024 words at 0) and one 3-cycle instance
// (16 words at 0x1000), sharing clock and reset.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        req0, we0, gnt0, rvalid0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0]  be0;
  logic        req3, we3, gnt3, rvalid3, err3;
  logic [31:0] addr3, wdata3, rdata3;
  logic [3:0]  be3;

  int n_cmp;
  int n_err;

  dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req0), .data_gnt_o(gnt0), .data_rvalid_o(rvalid0),
    .data_addr_i(addr0), .data_we_i(we0), .data_be_i(be0), .data_wdata_i(wdata0),
    .data_rdata_o(rdata0), .data_err_o(err0)
  );

  dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .data_req_i(req3), .data_gnt_o(gnt3), .data_rvalid_o(rvalid3),
    .data_addr_i(addr3), .data_we_i(we3), .data_be_i(be3), .data_wdata_i(wdata3),
    .data_rdata_o(rdata3), .data_err_o(err3)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do0(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    cyc();
    req0 = 1'b1; we0 = we; addr0 = addr; be0 = be; wdata0 = wd;
    smp();
    chk({tag, ".gnt"}, 32'(gnt0), 32'd1);
    cyc();
    req0 = 1'b0;
    smp();
    chk({tag, ".rvalid"}, 32'(rvalid0), 32'd1);
    chk({tag, ".rdata"}, rdata0, exp_rd);
    chk({tag, ".err"}, 32'(err0), 32'(exp_err));
  endtask

  task automatic do3(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    cyc();
    req3 = 1'b1; we3 = we; addr3 = addr; be3 = 4'hF; wdata3 = wd;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) cyc();
      smp();
      chk($sformatf("%s.gnt_c%0d", tag, c), 32'(gnt3), (c == 3) ? 32'd1 : 32'd0);
      chk($sformatf("%s.rvalid_c%0d", tag, c), 32'(rvalid3), 32'd0);
    end
    cyc();
    req3 = 1'b0;
    smp();
    chk({tag, ".rvalid_c4"}, 32'(rvalid3), 32'd1);
    chk({tag, ".rdata"}, rdata3, exp_rd);
    chk({tag, ".err"}, 32'(err3), 32'(exp_err));
  endtask

  // Directed stimulus sequence.
  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; be0 = 4'hF; wdata0 = 32'h0;
    req3 = 1'b1; we3 = 1'b0; addr3 = 32'h1000; be3 = 4'hF; wdata3 = 32'h0;

    cyc();
    cyc();
    smp();
    chk("rst.gnt0", 32'(gnt0), 32'd0);
    chk("rst.rvalid0", 32'(rvalid0), 32'd0);
    chk("rst.rdata0", rdata0, 32'h0);
    chk("rst.err0", 32'(err0), 32'd0);
    chk("rst.gnt3", 32'(gnt3), 32'd0);
    chk("rst.rvalid3", 32'(rvalid3), 32'd0);
    req0 = 1'b0;
    req3 = 1'b0;
    cyc();
    rst = 1'b0;

    do0(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0, "wr10");
    do0(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "rd10");
    do0(1'b0, 32'h13, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0, "rd13_lowbits");

    do0(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0, 1'b0, "wr20");
    do0(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'h0, 1'b0, "wr20_be0101");
    do0(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, "rd20_merged");
    do0(1'b1, 32'h20, 4'b0000, 32'hFFFFFFFF, 32'h0, 1'b0, "wr20_be0000");
    do0(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, "rd20_unchanged");

    do0(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, "wr0");
    do0(1'b1, 32'hFFC, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, "wr_top");
    do0(1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0, 1'b1, "wr_oor");
    do0(1'b0, 32'h1000, 4'hF, 32'h0, 32'h0, 1'b1, "rd_oor");
    do0(1'b0, 32'hFFC, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, "rd_top");
    do0(1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFEF00D, 1'b0, "rd0_after_oor");
    cyc();
    smp();
    chk("hold.rvalid", 32'(rvalid0), 32'd0);
    chk("hold.rdata", rdata0, 32'hCAFEF00D);
    chk("hold.err", 32'(err0), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do0(1'b1, 32'h40 + 32'(i) * 32'd4, 4'hF, 32'hA500_0000 + 32'(i), 32'h0, 1'b0,
          $sformatf("fill%0d", i));
    end
    cyc();
    for (int i = 0; i < 8; i++) begin
      req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h40 + 32'(i) * 32'd4;
      smp();
      chk($sformatf("b2b.gnt%0d", i), 32'(gnt0), 32'd1);
      chk($sformatf("b2b.rvalid%0d", i), 32'(rvalid0), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("b2b.rdata%0d", i - 1), rdata0, 32'hA500_0000 + 32'(i - 1));
      cyc();
    end
    req0 = 1'b0;
    smp();
    chk("b2b.rvalid_last", 32'(rvalid0), 32'd1);
    chk("b2b.rdata7", rdata0, 32'hA500_0007);

    cyc();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h60; be0 = 4'hF; wdata0 = 32'h55AA55AA;
    smp();
    chk("raw.gnt_wr", 32'(gnt0), 32'd1);
    cyc();
    we0 = 1'b0;
    smp();
    chk("raw.gnt_rd", 32'(gnt0), 32'd1);
    cyc();
    req0 = 1'b0;
    smp();
    chk("raw.rvalid", 32'(rvalid0), 32'd1);
    chk("raw.rdata", rdata0, 32'h55AA55AA);

    do3(1'b1, 32'h1008, 32'h31415926, 32'h0, 1'b0, "w3_wr");
    do3(1'b0, 32'h1008, 32'h0, 32'h31415926, 1'b0, "w3_rd");
    cyc();
    req3 = 1'b1; we3 = 1'b1; addr3 = 32'h1008; wdata3 = 32'hFFFFFFFF;
    smp();
    chk("drop.gnt_c0", 32'(gnt3), 32'd0);
    cyc();
    smp();
    chk("drop.gnt_c1", 32'(gnt3), 32'd0);
    cyc();
    req3 = 1'b0;
    smp();
    chk("drop.gnt_c2", 32'(gnt3), 32'd0);
    for (int c = 0; c < 4; c++) begin
      cyc();
      smp();
      chk($sformatf("drop.rvalid_after%0d", c), 32'(rvalid3), 32'd0);
    end
    do3(1'b0, 32'h1008, 32'h0, 32'h31415926, 1'b0, "w3_rd_after_drop");
    do3(1'b1, 32'h103C, 32'h76543210, 32'h0, 1'b0, "w3_wr_top");
    do3(1'b0, 32'h103C, 32'h0, 32'h76543210, 1'b0, "w3_rd_top");
    do3(1'b0, 32'h0FFC, 32'h0, 32'h0, 1'b1, "w3_rd_below");
    do3(1'b1, 32'h1040, 32'h13579BDF, 32'h0, 1'b1, "w3_wr_above");

    cyc();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; be0 = 4'hF;
    smp();
    chk("arst.gnt", 32'(gnt0), 32'd1);
    cyc();
    req0 = 1'b0;
    chk("arst.rvalid_before", 32'(rvalid0), 32'd1);
    chk("arst.rdata_before", rdata0, 32'hDEADBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("arst.rvalid", 32'(rvalid0), 32'd0);
    chk("arst.rdata", rdata0, 32'h0);
    chk("arst.err", 32'(err0), 32'd0);
    smp();
    cyc();
    rst = 1'b0;
    smp();
    chk("arst.rvalid_release", 32'(rvalid0), 32'd0);
    do0(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, "rd10_after_rst");
    do0(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB33DD, 1'b0, "rd20_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
